wb_writer: RTL

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_writer_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 52 +++++
 rtl/wb_writer.sv | 71 +++++++
 3 files changed

// File: rtl/wb_writer_pkg.sv
// Shared definitions for the write-back writer: processor phase codes and the FIFO entry layout.
package wb_writer_pkg;

    typedef enum logic [2:0] {
        STATE_IF     = 3'd0,
        STATE_RF     = 3'd1,
        STATE_EX     = 3'd2,
        STATE_MEM    = 3'd3,
        STATE_WB     = 3'd4,
        STATE_OUTPUT = 3'd5
    } phase_t;

    localparam int RD_W      = 5;
    localparam int DATA_W    = 8;
    localparam int ENTRY_W   = RD_W + DATA_W;
    localparam int COUNT_W   = 4;
    localparam int RETIRED_W = 8;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic is_wb_phase(input logic [2:0] code);
        return code == STATE_WB;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write storage: a power-of-two circular buffer of {rd, data} entries with an occupancy count.
module wb_fifo
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] head,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    // Storage needs no reset; the count decides whether the head is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: queues execute results and retires one per WB phase to the register file.
// Optional macro WB_R0_GUARD_EN suppresses register-file writes whose destination is register 0.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           state,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RD_W-1:0]      in_rd,
    input  logic [DATA_W-1:0]    in_data,
    output logic [RD_W-1:0]      rdestination,
    output logic [DATA_W-1:0]    result,
    output logic                 result_valid,
    output logic [COUNT_W-1:0]   pending,
    output logic [RETIRED_W-1:0] retired
);

    wb_entry_t          offered;
    wb_entry_t          head;
    logic [ENTRY_W-1:0] head_bits;
    logic               push;
    logic               pop;
    logic               nonempty;
    logic               head_writable;

    assign offered.rd   = in_rd;
    assign offered.data = in_data;

    assign in_ready = (pending < COUNT_W'(DEPTH));
    assign nonempty = (pending != '0);
    assign push     = in_valid && in_ready;
    assign pop      = is_wb_phase(state) && nonempty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (offered),
        .head  (head_bits),
        .count (pending)
    );

    assign head = wb_entry_t'(head_bits);

`ifdef WB_R0_GUARD_EN
    assign head_writable = (head.rd != '0);
`else
    assign head_writable = 1'b1;
`endif

    // Stale storage contents are hidden whenever the queue is empty.
    assign rdestination = nonempty ? head.rd   : '0;
    assign result       = nonempty ? head.data : '0;
    assign result_valid = pop && head_writable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (pop) begin
            retired <= retired + 1'b1;
        end
    end

endmodule
